// File: rtl/acc_drain.sv
// acc_drain: readout stage for the folded fully-connected accumulator bank.
// Captures the per-lane popcount sums into a shadow register, pulses
// swap/clear back to the accumulator, then streams one lane per handshake.
// Optional build macro: BINARIZE_EN (1-bit sign activation instead of the
// signed bipolar dot product).
module acc_drain #(
    parameter int LANES = 8,
    parameter int SUM_W = 16,
    parameter int TOTAL = 110,
    parameter int IDX_W = (LANES > 1) ? $clog2(LANES) : 1,
`ifdef BINARIZE_EN
    localparam int OUT_W = 1
`else
    localparam int OUT_W = SUM_W + 2
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [LANES*SUM_W-1:0] sum,
    output logic                   swap_o,
    output logic                   clear_o,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_last,
    output logic                   overrun
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(LANES - 1);
    localparam logic [SUM_W+1:0]   TOTAL_C  = (SUM_W + 2)'(TOTAL);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               pulse_reg, pulse_next;
    logic               overrun_reg, overrun_next;
    logic [SUM_W-1:0]   shadow_reg [LANES];
    logic [SUM_W-1:0]   sum_lane [LANES];
    logic [SUM_W-1:0]   sel_sum;
    logic [SUM_W+1:0]   dbl_sum;
    logic               fire;
    logic               at_last;
    logic               accept;

    // Split the packed input bus into per-lane words, lane 0 in the LSBs.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign sum_lane[gi] = sum[gi*SUM_W +: SUM_W];
    end

    // State register: FSM state, lane index, swap/clear pulse and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            pulse_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            pulse_reg   <= pulse_next;
            overrun_reg <= overrun_next;
        end
    end

    // Shadow copy of the sums; only written when a capture is accepted, so it
    // is frozen for the whole stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) shadow_reg[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < LANES; i++) shadow_reg[i] <= sum_lane[i];
        end
    end

    // Next-state logic: a capture is taken when idle or on the final
    // handshake (back-to-back, no bubble); any other load while streaming
    // is dropped and flagged.
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        overrun_next = overrun_reg;
        fire         = (state_reg == STREAM) && out_ready;
        at_last      = (idx_reg == LAST_IDX);
        accept       = load && ((state_reg == IDLE) || (fire && at_last));
        pulse_next   = accept;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    state_next = STREAM;
                    idx_next   = '0;
                end
            end
            STREAM: begin
                if (fire) begin
                    if (at_last) begin
                        idx_next   = '0;
                        state_next = load ? STREAM : IDLE;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
                if (load && !(fire && at_last)) begin
                    overrun_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Lane result: 2*sum - TOTAL (or its sign), forced to zero when idle so
    // the bus is quiet outside a stream.
    always_comb begin
        sel_sum = shadow_reg[idx_reg];
        dbl_sum = {1'b0, sel_sum, 1'b0};
`ifdef BINARIZE_EN
        out_data = (state_reg == STREAM) && (dbl_sum >= TOTAL_C);
`else
        out_data = (state_reg == STREAM) ? (dbl_sum - TOTAL_C) : '0;
`endif
    end

    assign busy      = (state_reg == STREAM);
    assign out_valid = (state_reg == STREAM);
    assign out_idx   = idx_reg;
    assign out_last  = (state_reg == STREAM) && at_last;
    assign swap_o    = pulse_reg;
    assign clear_o   = pulse_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_acc_drain.sv
// tb_acc_drain: self-checking bench for acc_drain. Works in both the default
// build and with BINARIZE_EN defined. Main instance: LANES=4, SUM_W=8,
// TOTAL=100; second instance: LANES=1.
module tb_acc_drain;

    localparam int L  = 4;
    localparam int SW = 8;
    localparam int T  = 100;
`ifdef BINARIZE_EN
    localparam int OW = 1;
`else
    localparam int OW = SW + 2;
`endif

    logic clk;
    logic rst_n;

    logic            load4, ready4;
    logic [L*SW-1:0] sum4;
    logic            swap4, clear4, busy4, valid4, last4, ovr4;
    logic [OW-1:0]   data4;
    logic [1:0]      idx4;

    logic            load1, ready1;
    logic [SW-1:0]   sum1;
    logic            swap1, clear1, busy1, valid1, last1, ovr1;
    logic [OW-1:0]   data1;
    logic [0:0]      idx1;

    int n_checks = 0;
    int n_fail   = 0;

    acc_drain #(.LANES(L), .SUM_W(SW), .TOTAL(T)) dut4 (
        .clk(clk), .rst_n(rst_n), .load(load4), .sum(sum4),
        .swap_o(swap4), .clear_o(clear4), .busy(busy4),
        .out_valid(valid4), .out_ready(ready4), .out_data(data4),
        .out_idx(idx4), .out_last(last4), .overrun(ovr4)
    );

    acc_drain #(.LANES(1), .SUM_W(SW), .TOTAL(T)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load1), .sum(sum1),
        .swap_o(swap1), .clear_o(clear1), .busy(busy1),
        .out_valid(valid1), .out_ready(ready1), .out_data(data1),
        .out_idx(idx1), .out_last(last1), .overrun(ovr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int s[4];
        int bip[4];
        int bin[4];
    } vec_t;

    vec_t tbl[3];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // Reference result for one lane, straight from the arithmetic definition.
    function automatic int ref_word(int s);
`ifdef BINARIZE_EN
        return (2 * s >= T) ? 1 : 0;
`else
        return 2 * s - T;
`endif
    endfunction

    function automatic logic [31:0] got(logic [OW-1:0] d);
`ifdef BINARIZE_EN
        return {31'b0, d};
`else
        return {{(32-OW){d[OW-1]}}, d};
`endif
    endfunction

    function automatic logic [L*SW-1:0] pack4(int a, int b, int c, int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic int tbl_exp(int i, int k);
`ifdef BINARIZE_EN
        return tbl[i].bin[k];
`else
        return tbl[i].bip[k];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_lane(string tag, int k, int expv, bit exp_pulse);
        $display("%s lane %0d: valid=%0b data=%0d idx=%0d last=%0b swap=%0b",
                 tag, k, valid4, $signed(got(data4)), idx4, last4, swap4);
        check({tag, " valid"}, 32'(valid4), 32'd1);
        check({tag, " data"},  got(data4), 32'(expv));
        check({tag, " idx"},   32'(idx4),  32'(k));
        check({tag, " last"},  32'(last4), 32'(k == L - 1));
        check({tag, " swap"},  32'(swap4), 32'(exp_pulse));
        check({tag, " clear"}, 32'(clear4), 32'(exp_pulse));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Randomized run against a queue model: the queue holds the words still
    // to be delivered; a load is taken only when nothing is pending or the
    // last pending word leaves on the same edge.
    task automatic random_run(int cycles);
        int  q[$];
        bit  pulse_exp;
        bit  ovr_exp;
        bit  fire;
        bit  last_fire;
        bit  idle;
        int  s[4];
        pulse_exp = 1'b0;
        ovr_exp   = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            check("rnd valid", 32'(valid4), 32'(q.size() > 0));
            check("rnd busy",  32'(busy4),  32'(q.size() > 0));
            if (q.size() > 0) begin
                check("rnd data", got(data4), 32'(q[0]));
                check("rnd idx",  32'(idx4),  32'(L - q.size()));
                check("rnd last", 32'(last4), 32'(q.size() == 1));
            end
            check("rnd swap",    32'(swap4),  32'(pulse_exp));
            check("rnd clear",   32'(clear4), 32'(pulse_exp));
            check("rnd overrun", 32'(ovr4),   32'(ovr_exp));
            ready4 = ($urandom_range(0, 3) != 0);
            load4  = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < 4; i++) s[i] = int'($urandom_range(0, 255));
            sum4 = pack4(s[0], s[1], s[2], s[3]);
            idle      = (q.size() == 0);
            fire      = (q.size() > 0) && ready4;
            last_fire = fire && (q.size() == 1);
            if (fire) void'(q.pop_front());
            pulse_exp = 1'b0;
            if (load4) begin
                if (idle || last_fire) begin
                    for (int i = 0; i < 4; i++) q.push_back(ref_word(s[i]));
                    pulse_exp = 1'b1;
                end else begin
                    ovr_exp = 1'b1;
                end
            end
            tick();
        end
        load4  = 1'b0;
        ready4 = 1'b1;
        $display("random run: %0d cycles, final overrun=%0b", cycles, ovr4);
    endtask

    initial begin
        int hs;
        rst_n  = 1'b0;
        load4  = 1'b0; ready4 = 1'b0; sum4 = '0;
        load1  = 1'b0; ready1 = 1'b0; sum1 = '0;

        tbl[0].s = '{50, 0, 255, 73};  tbl[0].bip = '{0, -100, 410, 46};   tbl[0].bin = '{1, 0, 1, 1};
        tbl[1].s = '{1, 2, 3, 4};      tbl[1].bip = '{-98, -96, -94, -92}; tbl[1].bin = '{0, 0, 0, 0};
        tbl[2].s = '{49, 51, 128, 0};  tbl[2].bip = '{-2, 2, 156, -100};   tbl[2].bin = '{0, 1, 1, 0};

        // Reset values, sampled both during and after reset.
        #1;
        for (int p = 0; p < 2; p++) begin
            $display("reset phase %0d: valid=%0b busy=%0b swap=%0b ovr=%0b", p, valid4, busy4, swap4, ovr4);
            check("rst valid",   32'(valid4), 32'd0);
            check("rst busy",    32'(busy4),  32'd0);
            check("rst swap",    32'(swap4),  32'd0);
            check("rst clear",   32'(clear4), 32'd0);
            check("rst overrun", 32'(ovr4),   32'd0);
            check("rst data",    got(data4),  32'd0);
            check("rst idx",     32'(idx4),   32'd0);
            check("rst last",    32'(last4),  32'd0);
            check("rst valid1",  32'(valid1), 32'd0);
            if (p == 0) begin
                tick();
                rst_n = 1'b1;
                tick();
            end
        end

        // Table-driven streams with out_ready held high.
        for (int i = 0; i < 3; i++) begin
            sum4 = pack4(tbl[i].s[0], tbl[i].s[1], tbl[i].s[2], tbl[i].s[3]);
            load4 = 1'b1; ready4 = 1'b1;
            tick();
            load4 = 1'b0;
            for (int k = 0; k < L; k++) begin
                check_lane($sformatf("tbl%0d", i), k, tbl_exp(i, k), k == 0);
                tick();
            end
            check("tbl end valid", 32'(valid4), 32'd0);
            check("tbl end busy",  32'(busy4),  32'd0);
            check("tbl end swap",  32'(swap4),  32'd0);
        end

        // Stalled stream: ready pattern 1,0,0,1; every lane held, none skipped.
        sum4 = pack4(tbl[0].s[0], tbl[0].s[1], tbl[0].s[2], tbl[0].s[3]);
        load4 = 1'b1; ready4 = 1'b0;
        tick();
        load4 = 1'b0;
        hs = 0;
        for (int c = 0; c < 16; c++) begin
            ready4 = (c % 4 == 0) || (c % 4 == 3);
            check("stall valid", 32'(valid4), 32'(hs < L));
            if (hs < L) begin
                check("stall data", got(data4), 32'(tbl_exp(0, hs)));
                check("stall idx",  32'(idx4),  32'(hs));
            end
            $display("stall cycle %0d: ready=%0b valid=%0b idx=%0d handshakes=%0d", c, ready4, valid4, idx4, hs);
            if (valid4 && ready4) hs++;
            tick();
        end
        check("stall handshakes", 32'(hs), 32'(L));
        check("stall overrun", 32'(ovr4), 32'd0);
        ready4 = 1'b1;

        // Load during lane 1 is dropped; load on the lane-3 handshake is taken.
        sum4 = pack4(tbl[0].s[0], tbl[0].s[1], tbl[0].s[2], tbl[0].s[3]);
        load4 = 1'b1;
        tick();
        load4 = 1'b0;
        check_lane("ovr A", 0, tbl_exp(0, 0), 1'b1);
        tick();
        sum4 = pack4(tbl[2].s[0], tbl[2].s[1], tbl[2].s[2], tbl[2].s[3]);
        load4 = 1'b1;
        check_lane("ovr A", 1, tbl_exp(0, 1), 1'b0);
        tick();
        load4 = 1'b0;
        check("ovr sticky1", 32'(ovr4), 32'd1);
        check_lane("ovr A", 2, tbl_exp(0, 2), 1'b0);
        tick();
        load4 = 1'b1;
        check_lane("ovr A", 3, tbl_exp(0, 3), 1'b0);
        tick();
        load4 = 1'b0;
        for (int k = 0; k < L; k++) begin
            check_lane("ovr B", k, tbl_exp(2, k), k == 0);
            check("ovr sticky", 32'(ovr4), 32'd1);
            tick();
        end
        check("ovr end valid", 32'(valid4), 32'd0);
        check("ovr held idle", 32'(ovr4), 32'd1);

        // Reset at lane 2 clears everything at once.
        sum4 = pack4(tbl[1].s[0], tbl[1].s[1], tbl[1].s[2], tbl[1].s[3]);
        load4 = 1'b1;
        tick();
        load4 = 1'b0;
        tick();
        tick();
        check("pre-rst idx", 32'(idx4), 32'd2);
        rst_n = 1'b0;
        #1;
        $display("mid-stream reset: valid=%0b busy=%0b ovr=%0b", valid4, busy4, ovr4);
        check("mrst valid",   32'(valid4), 32'd0);
        check("mrst busy",    32'(busy4),  32'd0);
        check("mrst overrun", 32'(ovr4),   32'd0);
        check("mrst data",    got(data4),  32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mrst swap idle", 32'(swap4), 32'd0);

        // Reset while the swap/clear pulse is high kills the pulse.
        load4 = 1'b1;
        tick();
        load4 = 1'b0;
        check("pulse before rst", 32'(swap4), 32'd1);
        rst_n = 1'b0;
        #1;
        check("prst swap",  32'(swap4),  32'd0);
        check("prst clear", 32'(clear4), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fresh capture after reset restarts at lane 0 with the new data.
        sum4 = pack4(tbl[2].s[0], tbl[2].s[1], tbl[2].s[2], tbl[2].s[3]);
        load4 = 1'b1;
        tick();
        load4 = 1'b0;
        for (int k = 0; k < L; k++) begin
            check_lane("post-rst", k, tbl_exp(2, k), k == 0);
            tick();
        end
        check("post-rst end", 32'(valid4), 32'd0);

        // Single-lane instance: one word, last high, then idle.
        sum1 = 8'(T / 2);
        load1 = 1'b1; ready1 = 1'b1;
        tick();
        load1 = 1'b0;
        $display("lanes1: valid=%0b data=%0d last=%0b swap=%0b", valid1, $signed(got(data1)), last1, swap1);
        check("l1 valid", 32'(valid1), 32'd1);
        check("l1 last",  32'(last1),  32'd1);
        check("l1 data",  got(data1),  32'(ref_word(T / 2)));
        check("l1 swap",  32'(swap1),  32'd1);
        tick();
        check("l1 end valid", 32'(valid1), 32'd0);
        check("l1 end busy",  32'(busy1),  32'd0);
        check("l1 overrun",   32'(ovr1),   32'd0);

        // Randomized traffic against the queue model, twice with a reset between.
        do_reset();
        random_run(300);
        do_reset();
        random_run(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
